// File: rtl/cic_decim_scaler_pkg.sv
// Shared defaults for the CIC decimation scaler slice.
// Holds the default data/config widths used by cic_decim_scaler and
// cic_round_shift. Optional build macro: CIC_DECIM_SAT_EN (saturating narrow).
package cic_decim_scaler_pkg;

  localparam int unsigned CIC_IN_WIDTH  = 16;
  localparam int unsigned CIC_OUT_WIDTH = 12;
  localparam int unsigned CIC_RATIO_W   = 8;
  localparam int unsigned CIC_SHIFT_W   = 5;

endpackage

// File: rtl/cic_round_shift.sv
// Registered round-half-up arithmetic right shift and narrow to OUT_WIDTH.
// Build option: CIC_DECIM_SAT_EN defined -> saturate to the signed OUT_WIDTH
// range; undefined -> keep the low OUT_WIDTH bits (modular wrap).
// Ports:
//   clk, reset_b  clock, async active-low reset
//   in_valid      in_data/in_shift carry a captured sample
//   in_data       signed IN_WIDTH sample
//   in_shift      right-shift amount (already clamped by the caller)
//   out_valid     registered: out_data carries a result
//   out_data      registered signed OUT_WIDTH result
module cic_round_shift
  import cic_decim_scaler_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = CIC_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = CIC_OUT_WIDTH,
  parameter int unsigned SHIFT_W   = CIC_SHIFT_W
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [SHIFT_W-1:0]   in_shift,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data
);

  // One guard bit so the rounding bias can never overflow.
  localparam int unsigned WW = IN_WIDTH + 1;

  logic signed [WW-1:0]  wide_c;
  logic signed [WW-1:0]  bias_c;
  logic signed [WW-1:0]  sum_c;
  logic signed [WW-1:0]  shifted_c;
  logic [OUT_WIDTH-1:0]  narrow_c;

`ifdef CIC_DECIM_SAT_EN
  localparam logic signed [WW-1:0] SAT_MAX = WW'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [WW-1:0] SAT_MIN = ~SAT_MAX;
`endif

  // Round half up, shift, then narrow.
  always_comb begin
    wide_c    = {in_data[IN_WIDTH-1], in_data};
    bias_c    = (in_shift == '0) ? '0 : (WW'(1) << (in_shift - SHIFT_W'(1)));
    sum_c     = wide_c + bias_c;
    shifted_c = sum_c >>> in_shift;
`ifdef CIC_DECIM_SAT_EN
    if (shifted_c > SAT_MAX) begin
      narrow_c = OUT_WIDTH'(SAT_MAX);
    end else if (shifted_c < SAT_MIN) begin
      narrow_c = OUT_WIDTH'(SAT_MIN);
    end else begin
      narrow_c = OUT_WIDTH'(shifted_c);
    end
`else
    narrow_c = OUT_WIDTH'(shifted_c);
`endif
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      out_data  <= narrow_c;
    end
  end

endmodule

// File: rtl/cic_decim_scaler.sv
// Decimates the full-rate CIC output by a programmable ratio, rescales for
// CIC bit growth and presents the result through a valid/ready register.
// Build option: CIC_DECIM_SAT_EN (saturating narrow, see cic_round_shift).
// Ports:
//   clk, reset_b  clock, async active-low reset
//   data_input    signed sample, valid every clk
//   cfg_ratio     decimation ratio R (0 treated as 1)
//   cfg_shift     right shift S (clamped to IN_WIDTH-1)
//   cfg_load      pulse: shadow cfg_*, adopt on next phase wrap
//   data_output   scaled decimated sample
//   out_valid     data_output holds an unconsumed sample
//   out_ready     consumer accepts when out_valid & out_ready
//   overflow      sticky: a result was dropped under backpressure
module cic_decim_scaler
  import cic_decim_scaler_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = CIC_IN_WIDTH,
  parameter int unsigned OUT_WIDTH = CIC_OUT_WIDTH,
  parameter int unsigned RATIO_W   = CIC_RATIO_W,
  parameter int unsigned SHIFT_W   = CIC_SHIFT_W
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic [IN_WIDTH-1:0]  data_input,
  input  logic [RATIO_W-1:0]   cfg_ratio,
  input  logic [SHIFT_W-1:0]   cfg_shift,
  input  logic                 cfg_load,
  output logic [OUT_WIDTH-1:0] data_output,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overflow
);

  localparam int unsigned MAX_SHIFT = IN_WIDTH - 1;

  logic [RATIO_W-1:0]   phase;
  logic [RATIO_W-1:0]   act_ratio;
  logic [RATIO_W-1:0]   shd_ratio;
  logic [SHIFT_W-1:0]   act_shift;
  logic [SHIFT_W-1:0]   shd_shift;
  logic                 pending;

  logic                 cap_valid;
  logic [IN_WIDTH-1:0]  cap_data;
  logic [SHIFT_W-1:0]   cap_shift;

  logic                 rs_valid;
  logic [OUT_WIDTH-1:0] rs_data;

  logic                 wrap_c;
  logic [RATIO_W-1:0]   ratio_c;
  logic [SHIFT_W-1:0]   shift_c;

  // Window end detection and sanitised configuration.
  always_comb begin
    wrap_c  = (phase == act_ratio - RATIO_W'(1));
    ratio_c = (cfg_ratio == '0) ? RATIO_W'(1) : cfg_ratio;
    shift_c = (cfg_shift > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : cfg_shift;
  end

  // Phase counter with shadowed config adopted only at a window boundary.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      phase     <= '0;
      act_ratio <= RATIO_W'(1);
      act_shift <= '0;
      shd_ratio <= RATIO_W'(1);
      shd_shift <= '0;
      pending   <= 1'b0;
    end else begin
      if (wrap_c) begin
        phase <= '0;
        if (pending) begin
          act_ratio <= shd_ratio;
          act_shift <= shd_shift;
        end
      end else begin
        phase <= phase + RATIO_W'(1);
      end
      // A load coinciding with an adoption stays pending for the next window.
      if (cfg_load) begin
        shd_ratio <= ratio_c;
        shd_shift <= shift_c;
        pending   <= 1'b1;
      end else if (wrap_c) begin
        pending   <= 1'b0;
      end
    end
  end

  // Capture stage; the shift travels with its sample.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_shift <= '0;
    end else begin
      cap_valid <= (phase == '0);
      cap_data  <= data_input;
      cap_shift <= act_shift;
    end
  end

  cic_round_shift #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .SHIFT_W   (SHIFT_W)
  ) u_round_shift (
    .clk       (clk),
    .reset_b   (reset_b),
    .in_valid  (cap_valid),
    .in_data   (cap_data),
    .in_shift  (cap_shift),
    .out_valid (rs_valid),
    .out_data  (rs_data)
  );

  // Output register: a stalled sample is kept, newer results are dropped.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      data_output <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (rs_valid) begin
        if (!out_valid || out_ready) begin
          data_output <= rs_data;
          out_valid   <= 1'b1;
        end else begin
          overflow    <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cic_decim_scaler.sv
`timescale 1ns/1ps
module tb_cic_decim_scaler;

  localparam int unsigned IN_WIDTH  = 16;
  localparam int unsigned OUT_WIDTH = 12;
  localparam int unsigned RATIO_W   = 8;
  localparam int unsigned SHIFT_W   = 5;

  logic                 clk = 1'b0;
  logic                 reset_b = 1'b0;
  logic [IN_WIDTH-1:0]  data_input = '0;
  logic [RATIO_W-1:0]   cfg_ratio = '0;
  logic [SHIFT_W-1:0]   cfg_shift = '0;
  logic                 cfg_load = 1'b0;
  logic [OUT_WIDTH-1:0] data_output;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic                 overflow;

  int n_checks = 0;
  int n_fail   = 0;

  cic_decim_scaler dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .data_input  (data_input),
    .cfg_ratio   (cfg_ratio),
    .cfg_shift   (cfg_shift),
    .cfg_load    (cfg_load),
    .data_output (data_output),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: floor((x + half) / 2^s), then narrow.
  function automatic logic [OUT_WIDTH-1:0] scale(input logic [IN_WIDTH-1:0] x, input int s);
    longint v;
    v = longint'($signed(x));
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
`ifdef CIC_DECIM_SAT_EN
    if (v > 2047) v = 2047;
    if (v < -2048) v = -2048;
`endif
    return OUT_WIDTH'(v);
  endfunction

  // Behavioural model: captures at the start of each R-long window,
  // results appear at the output two clocks after capture.
  int  m_ratio, m_shift, m_shd_ratio, m_shd_shift, m_pos;
  bit  m_pend;
  bit  m_s1_v, m_s2_v;
  logic [OUT_WIDTH-1:0] m_s1_d, m_s2_d;
  bit  m_valid, m_ovf;
  logic [OUT_WIDTH-1:0] exp_q[$];

  initial forever begin
    @(posedge clk or negedge reset_b);
    if (!reset_b) begin
      m_ratio = 1; m_shift = 0; m_shd_ratio = 1; m_shd_shift = 0;
      m_pos = 0; m_pend = 0; m_s1_v = 0; m_s2_v = 0;
      m_valid = 0; m_ovf = 0;
      exp_q.delete();
    end else begin
      if (m_s2_v) begin
        if (!m_valid || out_ready) begin
          exp_q.push_back(m_s2_d);
          m_valid = 1;
        end else begin
          m_ovf = 1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_s2_v = m_s1_v;
      m_s2_d = m_s1_d;
      m_s1_v = (m_pos == 0);
      m_s1_d = scale(data_input, m_shift);
      if (m_pos == m_ratio - 1) begin
        m_pos = 0;
        if (m_pend) begin
          m_ratio = m_shd_ratio;
          m_shift = m_shd_shift;
          m_pend  = 0;
        end
      end else begin
        m_pos++;
      end
      if (cfg_load) begin
        m_shd_ratio = (cfg_ratio == 0) ? 1 : int'(cfg_ratio);
        m_shd_shift = (cfg_shift > 15) ? 15 : int'(cfg_shift);
        m_pend = 1;
      end
    end
  end

  // Monitor: compares handshake state every cycle, pops on each acceptance.
  initial forever begin
    logic [OUT_WIDTH-1:0] exp;
    @(negedge clk);
    if (reset_b) begin
      check("out_valid", int'(out_valid), int'(m_valid));
      check("overflow", int'(overflow), int'(m_ovf));
      if (m_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 1, 0);
        end else begin
          exp = exp_q.pop_front();
          check("data_output", int'(data_output), int'(exp));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int r, input int s);
    cfg_ratio = RATIO_W'(r);
    cfg_shift = SHIFT_W'(s);
    cfg_load  = 1'b1;
    data_input = IN_WIDTH'($urandom);
    step();
    cfg_load  = 1'b0;
  endtask

  task automatic run_random(input int n, input bit rnd_ready);
    for (int i = 0; i < n; i++) begin
      data_input = IN_WIDTH'($urandom);
      out_ready  = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
  endtask

  task automatic check_reset_outputs();
    check("reset_data_output", int'(data_output), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_overflow", int'(overflow), 0);
  endtask

  initial begin
    int ramp;
    reset_b = 1'b0;
    repeat (3) step();
    check_reset_outputs();
    reset_b = 1'b1;
    step();

    // Ramp through R=4, S=0.
    cfg(4, 0);
    ramp = 0;
    for (int i = 0; i < 48; i++) begin
      data_input = IN_WIDTH'(ramp);
      ramp++;
      step();
    end

    // Rounding at S=4.
    cfg(1, 4);
    data_input = 16'h0018; step();
    data_input = 16'hFFE8; step();
    data_input = 16'h0017; step();
    run_random(10, 1'b0);

    // Narrowing extremes at S=0.
    cfg(1, 0);
    data_input = 16'h7FFF; step();
    data_input = 16'h8000; step();
    run_random(10, 1'b0);

    // Backpressure at R=2.
    cfg(2, 0);
    run_random(4, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      data_input = IN_WIDTH'($urandom);
      step();
    end
    run_random(20, 1'b0);

    // Reconfigure mid-window from R=8 to R=3, S=1.
    cfg(8, 0);
    run_random(21, 1'b0);
    cfg(3, 1);
    ramp = 1000;
    for (int i = 0; i < 40; i++) begin
      data_input = IN_WIDTH'(ramp);
      ramp += 7;
      step();
    end

    // Randomised config, data and backpressure; includes R=0 and S>15.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        cfg_ratio = RATIO_W'($urandom_range(0, 6));
        cfg_shift = SHIFT_W'($urandom_range(0, 31));
        cfg_load  = 1'b1;
      end else begin
        cfg_load  = 1'b0;
      end
      data_input = IN_WIDTH'($urandom);
      out_ready  = ($urandom_range(0, 3) != 0);
      step();
    end
    cfg_load = 1'b0;

    // Reset mid-stream for one clock.
    reset_b = 1'b0;
    #1;
    check_reset_outputs();
    step();
    reset_b = 1'b1;
    run_random(40, 1'b1);
    run_random(5, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
